boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Sits between the external byte link, the CPU and the main memory port on the motherboard.
- After `start`, receives a length-prefixed program image as bytes and assembles 16-bit words.
- Writes each word sequentially into main memory while holding the CPU in reset.
- When loading completes, releases the CPU and passes the CPU's memory signals straight through to memory.

Parameters:
- ADDR_W, 16: memory address width.
- DATA_W, 16: memory word width; must be 16 (two bytes per word).
- LOAD_BASE, 16'h0000: memory address of the first loaded word.
- MAX_WORDS, 8192: largest accepted image length in words (memory size).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- byte_in  in  8  incoming image byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader can accept a byte this cycle.
- cpu_mem_en  in  1  CPU memory enable.
- cpu_mem_rw  in  1  CPU write enable (1 = write).
- cpu_mem_addr  in  ADDR_W  CPU memory address.
- cpu_mem_din  in  DATA_W  CPU write data.
- mem_en  out  1  to memory enable.
- mem_rw  out  1  to memory write enable (1 = write).
- mem_addr  out  ADDR_W  to memory address.
- mem_din  out  DATA_W  to memory write data.
- cpu_hold  out  1  drives the CPU reset; 1 holds the CPU in reset.
- busy  out  1  a load is in progress.
- done  out  1  last load completed successfully.
- error  out  1  last load rejected because length > MAX_WORDS.
- word_count  out  16  number of words written in the current or last load.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); all state updates on the rising edge of clk.
- Reset values:
  - State is IDLE.
  - byte_ready=0, cpu_hold=1, busy=0, done=0, error=0, word_count=0.
  - mem_en=0, mem_rw=0, mem_addr=0, mem_din=0.
  - Length and word registers are 0.
- Byte handshake: a byte is accepted on a rising edge where byte_valid && byte_ready. Words are big-endian: the high byte comes first.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERR.
  - IDLE: byte_ready=0. start -> LEN_HI; clears word_count, done and error; sets busy=1.
  - LEN_HI: byte_ready=1. On accept, latch len[15:8] -> LEN_LO.
  - LEN_LO: byte_ready=1. On accept, latch len[7:0], then evaluate the full length:
    - len==0 -> DONE.
    - len>MAX_WORDS -> ERR.
    - otherwise -> DATA_HI.
  - DATA_HI: byte_ready=1. On accept, latch word[15:8] -> DATA_LO.
  - DATA_LO: byte_ready=1. On accept, latch word[7:0] -> WRITE.
  - WRITE: byte_ready=0. For exactly one cycle drive mem_en=1, mem_rw=1, mem_addr=LOAD_BASE+word_count (wraps modulo 2^ADDR_W), mem_din=word. At the end of the cycle word_count increments; if the new count equals len -> DONE, else -> DATA_HI.
  - DONE: busy=0, done=1, cpu_hold=0, byte_ready=0. mem_en/mem_rw/mem_addr/mem_din equal cpu_mem_* combinationally (zero-latency pass-through). start -> LEN_HI, asserting cpu_hold on the next cycle.
  - ERR: busy=0, error=1, cpu_hold=1, byte_ready=0. Only start or rst leaves this state.
- Outside DONE, the CPU memory inputs are ignored. mem_en=0 except in WRITE; mem_rw=0 except in WRITE.
- cpu_hold=1 in every state except DONE.
- Boundary cases:
  - start while busy is ignored.
  - byte_valid with byte_ready=0 is not consumed.
  - rst at any point, including mid-WRITE, aborts the load at the next edge: IDLE, cpu_hold=1, no further writes. A word already written stays in memory.
  - len==MAX_WORDS is accepted; len==MAX_WORDS+1 goes to ERR.
- Throughput: at most one word per 3 cycles (DATA_HI, DATA_LO, WRITE) with byte_valid held high.

Test Plan:
1. Reset, start, then bytes 00 02 12 34 AB CD with byte_valid held high -> two write cycles: addr 0000 data 1234, then addr 0001 data ABCD. Then done=1, cpu_hold=0, word_count=2, and 6 byte accepts total.
2. In DONE, drive cpu_mem_en=1, rw=0, addr=0001 -> mem_en=1, mem_addr=0001 in the same cycle. Memory returns ABCD on memout.
3. Start, bytes 00 00 -> DONE in the cycle after LEN_LO. No mem_en pulse; word_count=0.
4. Start, bytes 20 01 (8193 > MAX_WORDS) -> error=1, cpu_hold=1, byte_ready=0. A following start clears error and returns to LEN_HI.
5. Start, len=3, first word sent; assert rst during the second DATA_LO -> next cycle IDLE, cpu_hold=1, mem_en=0, word_count=0. Memory[0000] holds word 1.
6. Random byte_valid gaps (50% duty), len=4, LOAD_BASE=FFFE -> writes to FFFE, FFFF, 0000, 0001 in order, each exactly once. Data matches the stream, and byte_ready is never high in WRITE.

Source files
------------

// File: rtl/boot_loader.sv
// Boot loader: receives a length-prefixed big-endian byte image, writes it into
// main memory word by word with the CPU held in reset, then hands memory to the CPU.
module boot_loader #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] LOAD_BASE = '0,
  parameter int                MAX_WORDS = 8192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              cpu_mem_en,
  input  logic              cpu_mem_rw,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [DATA_W-1:0] cpu_mem_din,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_q, word_d;
  logic [15:0] count_d;
  logic [15:0] len_full;
  logic [15:0] count_inc;

  // Full length as it will be once the low byte currently on the link is latched.
  assign len_full  = {len_q[15:8], byte_in};
  assign count_inc = word_count + 16'd1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      len_q      <= '0;
      word_q     <= '0;
      word_count <= '0;
    end else begin
      state      <= state_d;
      len_q      <= len_d;
      word_q     <= word_d;
      word_count <= count_d;
    end
  end

  // NOTE: every output and next-state variable gets a default before the case,
  // otherwise a path that skips an assignment would infer a latch.
  always_comb begin
    state_d    = state;
    len_d      = len_q;
    word_d     = word_q;
    count_d    = word_count;
    byte_ready = 1'b0;
    cpu_hold   = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    mem_en     = 1'b0;
    mem_rw     = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;

    case (state)
      S_IDLE: begin
        if (start) begin
          count_d = '0;
          state_d = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (byte_valid) begin
          len_d   = {byte_in, len_q[7:0]};
          state_d = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (byte_valid) begin
          len_d = len_full;
          if (len_full == 16'd0)
            state_d = S_DONE;
          else if ({1'b0, len_full} > MAX_LEN)
            state_d = S_ERR;
          else
            state_d = S_DATA_HI;
        end
      end

      S_DATA_HI: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (byte_valid) begin
          word_d  = {byte_in, word_q[7:0]};
          state_d = S_DATA_LO;
        end
      end

      S_DATA_LO: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (byte_valid) begin
          word_d  = {word_q[15:8], byte_in};
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        busy     = 1'b1;
        mem_en   = 1'b1;
        mem_rw   = 1'b1;
        // Address wraps naturally at the top of the ADDR_W space.
        mem_addr = LOAD_BASE + ADDR_W'(word_count);
        mem_din  = DATA_W'(word_q);
        count_d  = count_inc;
        state_d  = (count_inc == len_q) ? S_DONE : S_DATA_HI;
      end

      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        mem_en   = cpu_mem_en;
        mem_rw   = cpu_mem_rw;
        mem_addr = cpu_mem_addr;
        mem_din  = cpu_mem_din;
        if (start) begin
          count_d = '0;
          state_d = S_LEN_HI;
        end
      end

      S_ERR: begin
        error = 1'b1;
        if (start) begin
          count_d = '0;
          state_d = S_LEN_HI;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed loads plus randomized streams,
// compared against a word-level model of the expected memory writes.
module tb_boot_loader;

  typedef logic [7:0]  bq_t [$];
  typedef logic [31:0] wq_t [$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        cpu_mem_en = 1'b0, cpu_mem_rw = 1'b0;
  logic [15:0] cpu_mem_addr = '0, cpu_mem_din = '0;

  logic        byte_ready0, mem_en0, mem_rw0, cpu_hold0, busy0, done0, error0;
  logic [15:0] mem_addr0, mem_din0, word_count0;
  logic        byte_ready1, mem_en1, mem_rw1, cpu_hold1, busy1, done1, error1;
  logic [15:0] mem_addr1, mem_din1, word_count1;

  int checks = 0;
  int errors = 0;
  int acc0 = 0, acc1 = 0, rdy_viol = 0;
  wq_t wq0, wq1;
  logic [15:0] mem_model [0:65535];

  always #5 clk = ~clk;

  boot_loader #(.ADDR_W(16), .DATA_W(16), .LOAD_BASE(16'h0000), .MAX_WORDS(8192)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready0), .cpu_mem_en(cpu_mem_en), .cpu_mem_rw(cpu_mem_rw),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_din(cpu_mem_din), .mem_en(mem_en0),
    .mem_rw(mem_rw0), .mem_addr(mem_addr0), .mem_din(mem_din0), .cpu_hold(cpu_hold0),
    .busy(busy0), .done(done0), .error(error0), .word_count(word_count0));

  boot_loader #(.ADDR_W(16), .DATA_W(16), .LOAD_BASE(16'hFFFE), .MAX_WORDS(8192)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready1), .cpu_mem_en(cpu_mem_en), .cpu_mem_rw(cpu_mem_rw),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_din(cpu_mem_din), .mem_en(mem_en1),
    .mem_rw(mem_rw1), .mem_addr(mem_addr1), .mem_din(mem_din1), .cpu_hold(cpu_hold1),
    .busy(busy1), .done(done1), .error(error1), .word_count(word_count1));

  // Inputs change just after the rising edge, so the falling edge sees exactly
  // what the next rising edge will sample.
  always @(negedge clk) begin
    if (mem_en0 && mem_rw0 && busy0) begin
      wq0.push_back({mem_addr0, mem_din0});
      mem_model[mem_addr0] = mem_din0;
    end
    if (mem_en1 && mem_rw1 && busy1) wq1.push_back({mem_addr1, mem_din1});
    if (byte_valid && byte_ready0) acc0++;
    if (byte_valid && byte_ready1) acc1++;
    if (byte_ready1 && mem_en1) rdy_viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Presents each byte until accepted; optional random idle gaps between bytes.
  task automatic send_bytes(input bq_t b, input bit gaps, input bit sel);
    foreach (b[i]) begin
      int budget;
      if (gaps) begin
        while ($urandom_range(1, 0) == 1) begin
          byte_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      byte_in    = b[i];
      byte_valid = 1'b1;
      budget     = 0;
      forever begin
        @(negedge clk);
        if (sel ? byte_ready1 : byte_ready0) break;
        budget++;
        if (budget > 50) begin
          timeout_fail("byte_accept");
          break;
        end
        if (gaps && $urandom_range(1, 0) == 1) begin
          @(posedge clk); #1;
          byte_valid = 1'b0;
          @(posedge clk); #1;
          byte_valid = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input string tag);
    for (int i = 0; i < 200; i++) begin
      if (sel ? done1 : done0) return;
      @(posedge clk); #1;
    end
    timeout_fail(tag);
  endtask

  // Reference: word i lands at base+i (mod 2^16) holding the i-th big-endian pair.
  function automatic wq_t expected_writes(input logic [15:0] words [$], input logic [15:0] base);
    wq_t q;
    foreach (words[i]) q.push_back({16'(base + 16'(i)), words[i]});
    return q;
  endfunction

  function automatic bq_t image_bytes(input logic [15:0] words [$]);
    bq_t q;
    int n = words.size();
    q.push_back(8'(n >> 8));
    q.push_back(8'(n));
    foreach (words[i]) begin
      q.push_back(words[i][15:8]);
      q.push_back(words[i][7:0]);
    end
    return q;
  endfunction

  task automatic check_writes(input string tag, input wq_t got, input wq_t exp);
    check({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_w%0d", tag, i), got[i], exp[i]);
  endtask

  initial begin
    bq_t b;
    logic [15:0] words [$];
    int acc_before;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_byte_ready", byte_ready0, 1'b0);
    check("rst_cpu_hold",   cpu_hold0,   1'b1);
    check("rst_flags",      {busy0, done0, error0}, 3'b000);
    check("rst_word_count", word_count0, 16'h0);
    check("rst_mem",        {mem_en0, mem_rw0, mem_addr0, mem_din0}, 34'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: two-word image with byte_valid held high
    acc0 = 0;
    wq0.delete();
    pulse_start(1'b0);
    check("t1_busy", busy0, 1'b1);
    words = {16'h1234, 16'hABCD};
    send_bytes(image_bytes(words), 1'b0, 1'b0);
    wait_done(1'b0, "t1_done_wait");
    check_writes("t1", wq0, expected_writes(words, 16'h0000));
    check("t1_done",       done0,       1'b1);
    check("t1_cpu_hold",   cpu_hold0,   1'b0);
    check("t1_busy_done",  busy0,       1'b0);
    check("t1_word_count", word_count0, 16'd2);
    check("t1_accepts",    acc0,        6);

    // 2: CPU pass-through in DONE, zero latency
    cpu_mem_en = 1'b1; cpu_mem_rw = 1'b0; cpu_mem_addr = 16'h0001; cpu_mem_din = 16'h5A5A;
    #1;
    check("t2_mem_en",   mem_en0,   1'b1);
    check("t2_mem_rw",   mem_rw0,   1'b0);
    check("t2_mem_addr", mem_addr0, 16'h0001);
    check("t2_mem_din",  mem_din0,  16'h5A5A);
    check("t2_memout",   mem_model[mem_addr0], 16'hABCD);
    cpu_mem_rw = 1'b1;
    #1;
    check("t2_mem_rw_wr", mem_rw0, 1'b1);
    cpu_mem_en = 1'b0; cpu_mem_rw = 1'b0;
    @(posedge clk); #1;

    // 3: zero-length image, restarted from DONE
    wq0.delete();
    cpu_mem_en = 1'b1; cpu_mem_rw = 1'b1;
    pulse_start(1'b0);
    check("t3_cpu_hold_restart", cpu_hold0, 1'b1);
    check("t3_mem_ignored",      mem_en0,   1'b0);
    check("t3_done_cleared",     done0,     1'b0);
    check("t3_word_count_clr",   word_count0, 16'd0);
    cpu_mem_en = 1'b0; cpu_mem_rw = 1'b0;
    b = {8'h00, 8'h00};
    send_bytes(b, 1'b0, 1'b0);
    check("t3_done",       done0,       1'b1);
    check("t3_no_writes",  wq0.size(),  0);
    check("t3_word_count", word_count0, 16'd0);

    // 4: oversize length goes to ERR; bytes not consumed there; start recovers
    pulse_start(1'b0);
    b = {8'h20, 8'h01};
    send_bytes(b, 1'b0, 1'b0);
    check("t4_error",      error0,      1'b1);
    check("t4_cpu_hold",   cpu_hold0,   1'b1);
    check("t4_byte_ready", byte_ready0, 1'b0);
    check("t4_busy",       busy0,       1'b0);
    acc_before = acc0;
    byte_in = 8'h77; byte_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t4_not_consumed", acc0, acc_before);
    check("t4_still_err",    error0, 1'b1);
    byte_valid = 1'b0;
    pulse_start(1'b0);
    check("t4_error_clr",  error0,      1'b0);
    check("t4_ready_lenhi", byte_ready0, 1'b1);
    // len == MAX_WORDS is accepted
    b = {8'h20, 8'h00};
    send_bytes(b, 1'b0, 1'b0);
    check("t4_max_ok", {error0, busy0, byte_ready0}, 3'b011);
    pulse_start(1'b0);
    check("t4_start_busy_ignored", {busy0, byte_ready0, word_count0}, {2'b11, 16'd0});

    // 5: reset during the second DATA_LO
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wq0.delete();
    pulse_start(1'b0);
    b = {8'h00, 8'h03, 8'hC0, 8'hDE, 8'hBE};
    send_bytes(b, 1'b0, 1'b0);
    byte_in = 8'hEF; byte_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    check("t5_idle",       {busy0, done0, error0, byte_ready0}, 4'b0000);
    check("t5_cpu_hold",   cpu_hold0,   1'b1);
    check("t5_mem_en",     mem_en0,     1'b0);
    check("t5_word_count", word_count0, 16'd0);
    rst = 1'b0; byte_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_writes("t5", wq0, expected_writes('{16'hC0DE}, 16'h0000));
    check("t5_mem0", mem_model[16'h0000], 16'hC0DE);

    // 6: random gaps, four words across the address wrap
    acc1 = 0; rdy_viol = 0;
    wq1.delete();
    words.delete();
    for (int i = 0; i < 4; i++) words.push_back(16'($urandom));
    pulse_start(1'b1);
    send_bytes(image_bytes(words), 1'b1, 1'b1);
    wait_done(1'b1, "t6_done_wait");
    check_writes("t6", wq1, expected_writes(words, 16'hFFFE));
    check("t6_word_count", word_count1, 16'd4);
    check("t6_accepts",    acc1,        10);
    check("t6_ready_in_write", rdy_viol, 0);

    // 7: random-length images with random gaps on the base-0 loader
    for (int t = 0; t < 3; t++) begin
      wq0.delete();
      words.delete();
      n = $urandom_range(6, 1);
      for (int i = 0; i < n; i++) words.push_back(16'($urandom));
      pulse_start(1'b0);
      send_bytes(image_bytes(words), 1'b1, 1'b0);
      wait_done(1'b0, "t7_done_wait");
      check_writes($sformatf("t7_%0d", t), wq0, expected_writes(words, 16'h0000));
      check($sformatf("t7_%0d_word_count", t), word_count0, 16'(n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
